shift_seq_unit: RTL

- Parametrised successor to the datapath shift-amount selector.
- Selects the shift amount from one of four sources: instruction shamt field, constant, or two register operands.
- Latches that amount together with an operand and an operation.
- Executes SLL/SRL/SRA/ROR iteratively over multiple cycles with a start/busy/done handshake; sits beside the ALU and is sequenced by the control FSM.

---
 rtl/shift_seq_if.sv | 28 ++
 rtl/shift_seq_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/shift_seq_if.sv
// Handshake and operand bundle between the control sequencer and the iterative shift unit.
// The master drives the request, operand and amount sources; the slave returns status and result.
`timescale 1ns/1ps
interface shift_seq_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        amt_sel;
    logic [DATA_W-1:0] amt_src_0;
    logic [DATA_W-1:0] amt_src_2;
    logic [DATA_W-1:0] amt_src_3;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    modport master (
        output start, op, data_in, amt_sel, amt_src_0, amt_src_2, amt_src_3,
        input  busy, done, err, result
    );

    modport slave (
        input  start, op, data_in, amt_sel, amt_src_0, amt_src_2, amt_src_3,
        output busy, done, err, result
    );
endinterface

// File: rtl/shift_seq_unit.sv
// Iterative SLL/SRL/SRA/ROR unit: selects a shift amount, latches operand and op on start,
// then shifts by up to STEP positions per cycle and pulses done with the registered result.
`timescale 1ns/1ps
module shift_seq_unit #(
    parameter int DATA_W    = 32,
    parameter int STEP      = 1,
    parameter int CONST_AMT = 16
) (
    input  logic       clk,
    input  logic       reset,
    shift_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam logic [SHAMT_W-1:0] STEP_AMT  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] CONST_SEL = SHAMT_W'(CONST_AMT);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_SRA  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] work;
    logic [SHAMT_W-1:0] remaining;
    logic [2:0]        op_q;
    logic              illegal_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] result_q;

    logic [SHAMT_W-1:0] sel_amt;
    logic              op_illegal;
    logic [SHAMT_W-1:0] k;
    logic [DATA_W-1:0] shifted;
    logic              unused_amt_hi;

    // One step of the latched operation; rotate is taken from the doubled word so no wrap math is needed.
    function automatic logic [DATA_W-1:0] shift_step(
        input logic [2:0]         o,
        input logic [DATA_W-1:0]  v,
        input logic [SHAMT_W-1:0] amt
    );
        logic signed [DATA_W-1:0] sv;
        logic [2*DATA_W-1:0]      rot;
        sv  = v;
        rot = {v, v} >> amt;
        case (o)
            OP_SLL:  shift_step = v << amt;
            OP_SRL:  shift_step = v >> amt;
            OP_SRA:  shift_step = sv >>> amt;
            OP_ROR:  shift_step = rot[DATA_W-1:0];
            default: shift_step = v;
        endcase
    endfunction

    always_comb begin
        sel_amt = bus.amt_src_0[SHAMT_W-1:0];
        case (bus.amt_sel)
            2'b01:   sel_amt = CONST_SEL;
            2'b10:   sel_amt = bus.amt_src_2[SHAMT_W-1:0];
            2'b11:   sel_amt = bus.amt_src_3[SHAMT_W-1:0];
            default: sel_amt = bus.amt_src_0[SHAMT_W-1:0];
        endcase
    end

    // Only the low SHAMT_W bits of each register source carry an amount.
    assign unused_amt_hi = ^{bus.amt_src_0[DATA_W-1:SHAMT_W],
                             bus.amt_src_2[DATA_W-1:SHAMT_W],
                             bus.amt_src_3[DATA_W-1:SHAMT_W]};

    assign op_illegal = (bus.op > OP_ROR);
    assign k          = (remaining < STEP_AMT) ? remaining : STEP_AMT;
    assign shifted    = shift_step(op_q, work, k);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            work      <= '0;
            remaining <= '0;
            op_q      <= OP_LOAD;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work      <= bus.data_in;
                        remaining <= sel_amt;
                        op_q      <= op_illegal ? OP_LOAD : bus.op;
                        illegal_q <= op_illegal;
                        busy_q    <= 1'b1;
                        if (op_illegal || (bus.op == OP_LOAD) || (sel_amt == '0)) begin
                            state    <= DONE;
                            result_q <= bus.data_in;
                            done_q   <= 1'b1;
                            err_q    <= op_illegal;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - k;
                    // Final step: publish the result as DONE is entered.
                    if (remaining == k) begin
                        state    <= DONE;
                        result_q <= shifted;
                        done_q   <= 1'b1;
                        err_q    <= illegal_q;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule
